// File: rtl/seq_left_rotator.sv
// Multi-cycle left barrel rotator: one log2 stage per clock, valid/ready on both sides.
// Latency from accept to out_valid is fixed at N edges regardless of the rotate amount.
module seq_left_rotator #(
    parameter int N = 3
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [2**N-1:0] a,
    input  logic [N-1:0] amt,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [2**N-1:0] y,
    output logic         busy
);
    localparam int W = 2**N;
    localparam logic [N-1:0] K_LAST = N[N-1:0] - 1'b1;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_t;

    state_t         state_q, state_d;
    logic [W-1:0]   data_q, data_d;
    logic [N-1:0]   amt_q, amt_d;
    logic [N-1:0]   k_q, k_d;
    logic [N-1:0]   amt_sh;
    logic           in_ready_q, out_valid_q, busy_q;

    // Upper half of {d,d} shifted left by 2**kk is d rotated left by 2**kk.
    function automatic logic [W-1:0] rotl_pow2(input logic [W-1:0] d, input logic [N-1:0] kk);
        logic [2*W-1:0] dd;
        dd = {d, d} << (1 << kk);
        return dd[2*W-1:W];
    endfunction

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        amt_d   = amt_q;
        k_d     = k_q;
        amt_sh  = amt_q >> k_q;
        case (state_q)
            IDLE: begin
                if (in_valid && in_ready_q) begin
                    data_d  = a;
                    amt_d   = amt;
                    k_d     = '0;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                if (amt_sh[0]) begin
                    data_d = rotl_pow2(data_q, k_q);
                end
                if (k_q == K_LAST) begin
                    state_d = DONE;
                end else begin
                    k_d = k_q + 1'b1;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            data_q      <= '0;
            amt_q       <= '0;
            k_q         <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            data_q      <= data_d;
            amt_q       <= amt_d;
            k_q         <= k_d;
            in_ready_q  <= (state_d == IDLE);
            out_valid_q <= (state_d == DONE);
            busy_q      <= (state_d != IDLE);
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign busy      = busy_q;
    assign y         = data_q;

endmodule

// File: tb/tb_seq_left_rotator.sv
// Bench for seq_left_rotator: an N=3 instance for timing/corner cases and an N=2
// instance for an exhaustive sweep, both checked against a scoreboard queue.
module tb_seq_left_rotator;
    logic       clk = 1'b0;
    logic       reset;

    logic       iv3, ir3, ov3, or3, busy3;
    logic [7:0] a3, y3;
    logic [2:0] amt3;

    logic       iv2, ir2, ov2, or2, busy2;
    logic [3:0] a2, y2;
    logic [1:0] amt2;

    int unsigned n_vec = 0;
    int unsigned n_err = 0;
    int unsigned cyc   = 0;

    logic [31:0] q3[$];
    logic [31:0] q2[$];

    typedef struct {
        logic [7:0] a;
        logic [2:0] amt;
        logic [7:0] y;
    } vec_t;

    vec_t vecs[8];

    seq_left_rotator #(.N(3)) dut (
        .clk(clk), .reset(reset), .in_valid(iv3), .in_ready(ir3), .a(a3), .amt(amt3),
        .out_valid(ov3), .out_ready(or3), .y(y3), .busy(busy3)
    );

    seq_left_rotator #(.N(2)) dut2 (
        .clk(clk), .reset(reset), .in_valid(iv2), .in_ready(ir2), .a(a2), .amt(amt2),
        .out_valid(ov2), .out_ready(or2), .y(y2), .busy(busy2)
    );

    always #5 clk = ~clk;

    task automatic cycle();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Reference taken straight from the functional definition: ({a,a} >> (W-amt)) low W bits.
    function automatic logic [31:0] rot_model(input logic [31:0] av, input int unsigned amv,
                                              input int unsigned w);
        logic [63:0] aa;
        if (amv == 0) return av;
        aa = ({32'd0, av} << w) | {32'd0, av};
        return 32'((aa >> (w - amv)) & ((64'd1 << w) - 64'd1));
    endfunction

    task automatic pop_check3(input string nm);
        logic [31:0] e;
        if (q3.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL %s: output %0h with empty scoreboard", nm, y3);
        end else begin
            e = q3.pop_front();
            check(nm, 32'(y3), e);
        end
    endtask

    task automatic run_op3(input logic [7:0] av, input logic [2:0] amv, input logic [7:0] ey);
        int unsigned lat;
        or3  = 1'b1;
        iv3  = 1'b1;
        a3   = av;
        amt3 = amv;
        check("in_ready_idle", 32'(ir3), 32'd1);
        cycle();
        iv3 = 1'b0;
        q3.push_back(32'(ey));
        check("in_ready_after_accept", 32'(ir3), 32'd0);
        check("busy_after_accept", 32'(busy3), 32'd1);
        lat = 0;
        while (!ov3 && lat < 10) begin
            cycle();
            lat++;
        end
        check("latency", lat, 32'd3);
        pop_check3("y_result");
        cycle();
        check("done_one_cycle", 32'(ov3), 32'd0);
        check("in_ready_after_done", 32'(ir3), 32'd1);
        check("busy_after_done", 32'(busy3), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{8'h81, 3'd1, 8'h03};
        vecs[1] = '{8'hB4, 3'd3, 8'hA5};
        vecs[2] = '{8'h01, 3'd7, 8'h80};
        vecs[3] = '{8'h5A, 3'd0, 8'h5A};
        vecs[4] = '{8'h00, 3'd5, 8'h00};
        vecs[5] = '{8'hFF, 3'd6, 8'hFF};
        vecs[6] = '{8'h80, 3'd1, 8'h01};
        vecs[7] = '{8'h3C, 3'd4, 8'hC3};

        reset = 1'b1;
        iv3 = 1'b0; a3 = '0; amt3 = '0; or3 = 1'b0;
        iv2 = 1'b0; a2 = '0; amt2 = '0; or2 = 1'b0;
        cycle();
        cycle();
        check("reset_y", 32'(y3), 32'd0);
        check("reset_out_valid", 32'(ov3), 32'd0);
        check("reset_in_ready", 32'(ir3), 32'd1);
        check("reset_busy", 32'(busy3), 32'd0);
        check("reset_n2_in_ready", 32'(ir2), 32'd1);
        reset = 1'b0;
        cycle();

        for (int unsigned i = 0; i < 8; i++) begin
            run_op3(vecs[i].a, vecs[i].amt, vecs[i].y);
        end

        // Backpressure: result held in DONE; a second operand is ignored.
        iv3 = 1'b1; a3 = 8'hB4; amt3 = 3'd3; or3 = 1'b0;
        cycle();
        q3.push_back(32'h0000_00A5);
        a3 = 8'hFF; amt3 = 3'd1;
        cycle(); cycle(); cycle();
        for (int unsigned i = 0; i < 5; i++) begin
            check("bp_out_valid", 32'(ov3), 32'd1);
            check("bp_y_hold", 32'(y3), 32'h0000_00A5);
            check("bp_in_ready", 32'(ir3), 32'd0);
            cycle();
        end
        or3 = 1'b1;
        pop_check3("bp_y_result");
        cycle();
        check("bp_release_in_ready", 32'(ir3), 32'd1);
        check("bp_release_out_valid", 32'(ov3), 32'd0);
        check("bp_ff_ignored_busy", 32'(busy3), 32'd0);
        iv3 = 1'b0;
        cycle();

        // Reset mid-operation, then reset held with in_valid high.
        iv3 = 1'b1; a3 = 8'h81; amt3 = 3'd1;
        cycle();
        iv3 = 1'b0;
        cycle();
        reset = 1'b1;
        cycle();
        check("rst_mid_out_valid", 32'(ov3), 32'd0);
        check("rst_mid_y", 32'(y3), 32'd0);
        check("rst_mid_in_ready", 32'(ir3), 32'd1);
        check("rst_mid_busy", 32'(busy3), 32'd0);
        iv3 = 1'b1; a3 = 8'h01; amt3 = 3'd2;
        cycle();
        check("rst_wins_busy", 32'(busy3), 32'd0);
        check("rst_wins_in_ready", 32'(ir3), 32'd1);
        reset = 1'b0;
        run_op3(8'h01, 3'd2, 8'h04);

        // Back-to-back with in_valid held high.
        begin : b2b
            logic [7:0]  opa[4];
            logic [2:0]  opm[4];
            int unsigned idx, got, guard, last_acc;
            bit          acc;
            for (int unsigned i = 0; i < 4; i++) begin
                opa[i] = 8'($urandom);
                opm[i] = 3'($urandom_range(0, 7));
            end
            idx = 0; got = 0; guard = 0; last_acc = 0;
            or3 = 1'b1; iv3 = 1'b1; a3 = opa[0]; amt3 = opm[0];
            while (got < 4 && guard < 100) begin
                if (ov3) begin
                    pop_check3("b2b_y");
                    got++;
                end
                acc = iv3 && ir3;
                cycle();
                guard++;
                if (acc) begin
                    q3.push_back(rot_model(32'(a3), 32'(amt3), 8));
                    if (idx > 0) check("b2b_accept_spacing", cyc - last_acc, 32'd5);
                    last_acc = cyc;
                    idx++;
                    if (idx < 4) begin
                        a3 = opa[idx]; amt3 = opm[idx];
                    end else begin
                        iv3 = 1'b0;
                    end
                end
            end
            check("b2b_results", got, 32'd4);
        end
        iv3 = 1'b0;
        cycle();

        // Exhaustive N=2 sweep with random consumer stalls.
        begin : sweep
            int unsigned pidx, got, guard;
            bit          acc;
            logic [31:0] e;
            pidx = 0; got = 0; guard = 0;
            iv2 = 1'b1; a2 = 4'd0; amt2 = 2'd0;
            while (got < 64 && guard < 2000) begin
                or2 = ($urandom_range(0, 3) != 0);
                if (ov2 && or2) begin
                    if (q2.size() == 0) begin
                        n_vec++;
                        n_err++;
                        $display("FAIL sweep_dup: output %0h with empty scoreboard", y2);
                    end else begin
                        e = q2.pop_front();
                        check("sweep_y", 32'(y2), e);
                    end
                    got++;
                end
                acc = iv2 && ir2;
                cycle();
                guard++;
                if (acc) begin
                    q2.push_back(rot_model(32'(a2), 32'(amt2), 4));
                    pidx++;
                    if (pidx < 64) begin
                        a2 = 4'(pidx >> 2); amt2 = 2'(pidx & 3);
                    end else begin
                        iv2 = 1'b0;
                    end
                end
            end
            check("sweep_results", got, 32'd64);
            check("sweep_accepts", pidx, 32'd64);
            check("sweep_queue_empty", q2.size(), 32'd0);
            or2 = 1'b1;
            cycle(); cycle(); cycle(); cycle(); cycle();
            check("sweep_no_extra_output", 32'(ov2), 32'd0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
